debouncer: RTL and testbench

DEBOUNCER -- requirements
Module: debouncer

---
 rtl/debouncer.sv | 115 +++++++++++
 tb/tb_debouncer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/debouncer.sv
// Debounces a synchronized level and counts accepted rising transitions (counter under DEBOUNCER_EVT_COUNTER_EN).
// Latency: out/rise/fall update at the STABLE_CYCLES-th consecutive edge sampling the new level.
// Backpressure: none; one sample per clk, clear_evt wins over a same-edge increment.
module debouncer #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned EVT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in,
  input  logic                 clear_evt,
  output logic                 out,
  output logic                 rise,
  output logic                 fall,
  output logic [EVT_WIDTH-1:0] evt_count,
  output logic                 evt_ovf
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  // The sample that would bring cnt to STABLE_CYCLES completes the check, so cnt never reaches it.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {LOW, CHK_HIGH, HIGH, CHK_LOW} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rise_nxt, fall_nxt, out_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= LOW;
      cnt   <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      LOW: begin
        if (in) begin
          state_nxt = CHK_HIGH;
          cnt_nxt   = CW'(1);
        end
      end
      CHK_HIGH: begin
        if (!in) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HIGH: begin
        if (!in) begin
          state_nxt = CHK_LOW;
          cnt_nxt   = CW'(1);
        end
      end
      CHK_LOW: begin
        if (in) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
    out_nxt = (state_nxt == HIGH) || (state_nxt == CHK_LOW);
  end

`ifdef DEBOUNCER_EVT_COUNTER_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      evt_count <= '0;
      evt_ovf   <= 1'b0;
    end else if (clear_evt) begin
      evt_count <= '0;
      evt_ovf   <= 1'b0;
    end else if (rise_nxt) begin
      evt_count <= evt_count + EVT_WIDTH'(1);
      if (evt_count == '1) evt_ovf <= 1'b1;
    end
  end
`else
  logic unused_clear_evt;
  assign unused_clear_evt = clear_evt;
  assign evt_count        = '0;
  assign evt_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer (STABLE_CYCLES=4, EVT_WIDTH=2); follows DEBOUNCER_EVT_COUNTER_EN if defined.
module tb_debouncer;
  localparam int N  = 4;
  localparam int EW = 2;
`ifdef DEBOUNCER_EVT_COUNTER_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn, din, clear_evt;
  logic out, rise, fall, evt_ovf;
  logic [EW-1:0] evt_count;

  debouncer #(.STABLE_CYCLES(N), .EVT_WIDTH(EW)) dut (
    .clk(clk), .resetn(resetn), .in(din), .clear_evt(clear_evt),
    .out(out), .rise(rise), .fall(fall), .evt_count(evt_count), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: out flips once the last N samples since reset all differ from it.
  logic m_out, m_rise, m_fall, m_ovf;
  int   m_evt;
  logic hist[$];

  typedef struct {
    logic i; logic c; logic o; logic r; logic f; int e; logic v;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_evt = 0; m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic i, input logic c);
    bit flip;
    hist.push_back(i);
    if (hist.size() > N) void'(hist.pop_front());
    m_rise = 1'b0; m_fall = 1'b0;
    if (hist.size() == N) begin
      flip = 1'b1;
      foreach (hist[k]) if (hist[k] == m_out) flip = 1'b0;
      if (flip) begin
        m_out  = !m_out;
        m_rise = m_out;
        m_fall = !m_out;
      end
    end
    if (EVT_EN) begin
      if (c) begin
        m_evt = 0; m_ovf = 1'b0;
      end else if (m_rise) begin
        m_evt = (m_evt + 1) % (1 << EW);
        if (m_evt == 0) m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("out", out, m_out);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("evt_count", evt_count, m_evt);
    chk("evt_ovf", evt_ovf, m_ovf);
    chk("rise_fall_excl", rise & fall, 0);
  endtask

  // Drive one sample, let one edge take it, then compare against the model.
  task automatic cycle(input logic i, input logic c);
    din = i; clear_evt = c;
    @(posedge clk); #1;
    model_step(i, c);
    check_model();
  endtask

  task automatic hold(input logic i, input int n);
    for (int k = 0; k < n; k++) cycle(i, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};

    resetn = 1'b0; din = 1'b0; clear_evt = 1'b0;
    model_reset();
    #2;
    chk("rst_out", out, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_evt", evt_count, 0);
    chk("rst_ovf", evt_ovf, 0);
    chk("rst_cnt", dut.cnt, 0);
    @(negedge clk); resetn = 1'b1;

    // Input already high out of reset, a 1-sample glitch, then a clean fall with clear.
    for (int k = 0; k < 12; k++) begin
      cycle(tbl[k].i, tbl[k].c);
      chk($sformatf("tbl%0d_out", k), out, tbl[k].o);
      chk($sformatf("tbl%0d_rise", k), rise, tbl[k].r);
      chk($sformatf("tbl%0d_fall", k), fall, tbl[k].f);
      chk($sformatf("tbl%0d_evt", k), evt_count, EVT_EN ? tbl[k].e : 0);
      chk($sformatf("tbl%0d_ovf", k), evt_ovf, EVT_EN ? tbl[k].v : 1'b0);
    end

    // Three-sample high glitch from LOW.
    hold(1'b1, 3);
    chk("glitch_hi_cnt3", dut.cnt, 3);
    cycle(1'b0, 1'b0);
    chk("glitch_hi_out", out, 0);
    chk("glitch_hi_cnt0", dut.cnt, 0);
    // Three-sample low glitch from HIGH.
    hold(1'b1, 4);
    chk("to_high_out", out, 1);
    hold(1'b0, 3);
    cycle(1'b1, 1'b0);
    chk("glitch_lo_out", out, 1);
    chk("glitch_lo_fall", fall, 0);
    chk("glitch_lo_cnt0", dut.cnt, 0);
    hold(1'b0, 4);
    chk("back_low_out", out, 0);

    // Four accepted rises wrap the 2-bit counter and set the sticky flag.
    for (int k = 1; k <= 4; k++) begin
      hold(1'b1, 4);
      chk($sformatf("wrap%0d_rise", k), rise, 1);
      chk($sformatf("wrap%0d_evt", k), evt_count, EVT_EN ? (k % 4) : 0);
      chk($sformatf("wrap%0d_ovf", k), evt_ovf, EVT_EN && (k == 4));
      hold(1'b0, 4);
    end
    chk("ovf_sticky", evt_ovf, EVT_EN);
    cycle(1'b0, 1'b1);
    chk("clear_evt", evt_count, 0);
    chk("clear_ovf", evt_ovf, 0);

    // Clear on the same edge as an accepted rise: the event is lost.
    hold(1'b1, 3);
    cycle(1'b1, 1'b1);
    chk("clr_rise_rise", rise, 1);
    chk("clr_rise_out", out, 1);
    chk("clr_rise_evt", evt_count, 0);
    hold(1'b0, 4);
    hold(1'b1, 4);
    hold(1'b0, 4);
    chk("pre_rst_evt", evt_count, EVT_EN ? 1 : 0);

    // Asynchronous reset in the middle of a rising check.
    hold(1'b1, 3);
    chk("mid_chk_cnt", dut.cnt, 3);
    #2 resetn = 1'b0;
    #1;
    chk("arst_out", out, 0);
    chk("arst_cnt", dut.cnt, 0);
    chk("arst_evt", evt_count, 0);
    chk("arst_rise", rise, 0);
    model_reset();
    @(negedge clk); resetn = 1'b1;
    hold(1'b1, 3);
    chk("post_rst_no_rise", rise, 0);
    cycle(1'b1, 1'b0);
    chk("post_rst_rise", rise, 1);

    // Random runs of 1..7 samples with occasional clears.
    for (int r = 0; r < 400; r++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) cycle(v, ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
